cm3_mac_ahb_master: RTL and testbench
=====================================

Name: cm3_mac_ahb_master

Overview:
- AHB-Lite single-transfer master that drives the memory-mapped MAC peripheral. The MAC peripheral map is: +0x0 data_a (WO), +0x4 data_b (WO), +0x8 result (RO, read clears accumulator).
- On start, the block fetches len operand pairs from two word arrays in memory and writes each pair to the MAC.
- It then reads the MAC result and stores it to a destination address.
- It offloads dot-product data movement from the CM3. It attaches as a second master on the AHB matrix.

Parameters:
- LEN_W, 16, width of element count.
- ADDR_W, 32, AHB address width.

Ports:
- hclk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; sampled only while idle.
- src_a  in  ADDR_W  word-aligned base of operand array A.
- src_b  in  ADDR_W  word-aligned base of operand array B.
- mac_base  in  ADDR_W  MAC peripheral base.
- dst  in  ADDR_W  result store address.
- len  in  LEN_W  number of element pairs.
- busy  out  1  job in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky; last job aborted on hresp.
- cycle_cnt  out  32  busy-cycle count (see Optional Feature).
- haddr  out  ADDR_W  AHB address.
- htrans  out  2  IDLE=2'b00 or NONSEQ=2'b10 only.
- hwrite  out  1  transfer direction.
- hsize  out  3  constant 3'b010 (word).
- hburst  out  3  constant 3'b000 (SINGLE).
- hwdata  out  32  write data.
- hrdata  in  32  read data.
- hready  in  1  transfer done / bus ready.
- hresp  in  1  1 = ERROR.

Behaviour:
- Reset values: busy=0, done=0, error=0, htrans=IDLE, haddr=0, hwrite=0, hwdata=0, cycle_cnt=0; internal state IDLE.
- Reset mid-job abandons the job with no done pulse. Reset takes priority over all other events.
- start and inputs: start is captured when state is IDLE. All inputs are latched on that edge. busy rises next cycle. Clearing error happens on that capture.
- start while busy is ignored.
- Transfers are non-overlapped. Each transfer is an address phase (htrans=NONSEQ, haddr/hwrite valid) followed by a data phase (htrans=IDLE).
- The address phase holds until hready=1.
- The data phase completes on hready=1. hwdata is driven throughout the data phase of writes and held across wait states.
- Read data is captured into an internal register on data-phase completion.
- States: IDLE, RA_A, RA_D, WA_A, WA_D, RB_A, RB_D, WB_A, WB_D, RR_A, RR_D, WR_A, WR_D, FIN. The _A suffix is the address phase; _D is the data phase.
- Per element i (0..len-1):
  - read src_a+4i
  - write it to mac_base+0x0
  - read src_b+4i
  - write it to mac_base+0x4
- After the last element:
  - read mac_base+0x8
  - write the value to dst
  - go to FIN
- FIN: done=1 for one cycle, busy=0, then IDLE.
- len=0: go straight to RR_A, then the result read/write sequence (flushes the accumulator).
- Element counter is LEN_W bits. Address offsets are computed modulo 2^ADDR_W, so wrap past 0xFFFFFFFC is silent.
- Timing with zero-wait slaves: busy lasts 8*len+4 cycles; done pulses the cycle after the WR_D completion.
- Error: hresp=1 during any data phase sets error=1.
  - The next cycle is FIN: htrans=IDLE, done pulses, and no further transfers are issued.
  - The first error cycle (hready=0) already drives htrans=IDLE.
- Master may be granted with hready=0 at address phase; haddr/htrans/hwrite are held stable until accepted.

Optional Feature:
- Macro: CM3_MAC_MASTER_CYCLE_CNT_EN.
- Defined: cycle_cnt clears on accepted start, increments every cycle busy=1, saturates at 0xFFFFFFFF, and holds after done until the next start.
- Undefined: cycle_cnt tied to 0 and no counter logic; the port is retained.

Test Plan:
- Zero-wait memory and MAC model, len=3, A={1,2,3}, B={4,5,6}:
  - MAC sees writes 1,4,2,5,3,6 to +0x0/+0x4.
  - One read of +0x8.
  - Result 32 is stored at dst.
  - busy is high 28 cycles, done pulses once, error=0.
- Same job with hready=0 for 2 cycles in every data phase and 1 cycle in every address phase: haddr/hwdata remain stable while hready=0; the result is still 32 and busy lasts 28+12*3+... equal to the model-measured count.
- len=0: only a read of mac_base+0x8 and a write to dst occur; busy lasts 4 cycles.
- hresp=1 (two-cycle ERROR) on the read of src_b+4 with len=4:
  - htrans=IDLE from the first error cycle.
  - error=1 and done pulses.
  - No writes to mac_base+0x4 for element 1.
- start pulse issued during busy: no effect on the transfer sequence.
- rst=1 mid-element: the next cycle has htrans=IDLE and busy=0, with no done pulse; a fresh start completes correctly.
- With CM3_MAC_MASTER_CYCLE_CNT_EN defined: cycle_cnt=28 after the zero-wait len=3 job.
- With CM3_MAC_MASTER_CYCLE_CNT_EN undefined: cycle_cnt=0 after the same job.

Source files
------------

// File: rtl/cm3_mac_ahb_master.sv
// cm3_mac_ahb_master
// AHB-Lite single-transfer master that feeds a memory-mapped MAC peripheral.
// On start it streams len (A[i], B[i]) word pairs from memory into the MAC
// (data_a at +0x0, data_b at +0x4). It then reads the result at +0x8, which
// also clears the accumulator, and stores that result at dst.
//
// Ports
//   hclk, rst            clock, synchronous active-high reset
//   start                one-cycle job request, honoured only while idle
//   src_a, src_b         word-aligned bases of operand arrays A and B
//   mac_base, dst        MAC peripheral base, result store address
//   len                  number of element pairs (0 = just flush the result)
//   busy, done, error    job status; error is sticky until the next start
//   cycle_cnt            busy-cycle counter (optional, see below)
//   haddr..hwdata        AHB-Lite master outputs (SINGLE, word transfers only)
//   hrdata, hready, hresp AHB-Lite master inputs
//
// Optional feature: define CM3_MAC_MASTER_CYCLE_CNT_EN to build the saturating
// busy-cycle counter. Without it cycle_cnt is tied to zero.
module cm3_mac_ahb_master #(
  parameter int LEN_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              hclk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_a,
  input  logic [ADDR_W-1:0] src_b,
  input  logic [ADDR_W-1:0] mac_base,
  input  logic [ADDR_W-1:0] dst,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       cycle_cnt,
  output logic [ADDR_W-1:0] haddr,
  output logic [1:0]        htrans,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [31:0]       hwdata,
  input  logic [31:0]       hrdata,
  input  logic              hready,
  input  logic              hresp
);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // _A states are address phases, _D states are data phases.
  typedef enum logic [3:0] {
    S_IDLE, S_RA_A, S_RA_D, S_WA_A, S_WA_D, S_RB_A, S_RB_D,
    S_WB_A, S_WB_D, S_RR_A, S_RR_D, S_WR_A, S_WR_D, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_ptr_q, a_ptr_d;
  logic [ADDR_W-1:0] b_ptr_q, b_ptr_d;
  logic [ADDR_W-1:0] mac_q, mac_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              error_q, error_d;

  assign hsize  = 3'b010;
  assign hburst = 3'b000;
  assign error  = error_q;

  always_comb begin
    state_d = state_q;
    a_ptr_d = a_ptr_q;
    b_ptr_d = b_ptr_q;
    mac_d   = mac_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    error_d = error_q;
    htrans  = HTRANS_IDLE;
    haddr   = '0;
    hwrite  = 1'b0;
    hwdata  = '0;
    busy    = 1'b1;
    done    = 1'b0;

    // In every data phase an ERROR response aborts the job at once; the FIN
    // cycle then overlaps the second ERROR cycle with htrans already IDLE.
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          a_ptr_d = src_a;
          b_ptr_d = src_b;
          mac_d   = mac_base;
          dst_d   = dst;
          cnt_d   = len;
          error_d = 1'b0;
          state_d = (len == '0) ? S_RR_A : S_RA_A;
        end
      end
      S_RA_A: begin
        htrans = HTRANS_NONSEQ;
        haddr  = a_ptr_q;
        if (hready) state_d = S_RA_D;
      end
      S_RA_D: begin
        if (hresp) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (hready) begin
          rdata_d = hrdata;
          state_d = S_WA_A;
        end
      end
      S_WA_A: begin
        htrans = HTRANS_NONSEQ;
        haddr  = mac_q;
        hwrite = 1'b1;
        if (hready) state_d = S_WA_D;
      end
      S_WA_D: begin
        hwdata = rdata_q;
        if (hresp) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (hready) begin
          state_d = S_RB_A;
        end
      end
      S_RB_A: begin
        htrans = HTRANS_NONSEQ;
        haddr  = b_ptr_q;
        if (hready) state_d = S_RB_D;
      end
      S_RB_D: begin
        if (hresp) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (hready) begin
          rdata_d = hrdata;
          state_d = S_WB_A;
        end
      end
      S_WB_A: begin
        htrans = HTRANS_NONSEQ;
        haddr  = mac_q + ADDR_W'(4);
        hwrite = 1'b1;
        if (hready) state_d = S_WB_D;
      end
      S_WB_D: begin
        hwdata = rdata_q;
        if (hresp) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (hready) begin
          // Pointers wrap modulo 2^ADDR_W by construction.
          a_ptr_d = a_ptr_q + ADDR_W'(4);
          b_ptr_d = b_ptr_q + ADDR_W'(4);
          cnt_d   = cnt_q - LEN_W'(1);
          state_d = (cnt_q == LEN_W'(1)) ? S_RR_A : S_RA_A;
        end
      end
      S_RR_A: begin
        htrans = HTRANS_NONSEQ;
        haddr  = mac_q + ADDR_W'(8);
        if (hready) state_d = S_RR_D;
      end
      S_RR_D: begin
        if (hresp) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (hready) begin
          rdata_d = hrdata;
          state_d = S_WR_A;
        end
      end
      S_WR_A: begin
        htrans = HTRANS_NONSEQ;
        haddr  = dst_q;
        hwrite = 1'b1;
        if (hready) state_d = S_WR_D;
      end
      S_WR_D: begin
        hwdata = rdata_q;
        if (hresp) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end else if (hready) begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        busy    = 1'b0;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state is reset; captured job parameters and read data are not,
  // since they are always loaded before use.
  always_ff @(posedge hclk) begin
    if (rst) begin
      state_q <= S_IDLE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      error_q <= error_d;
    end
  end

  always_ff @(posedge hclk) begin
    a_ptr_q <= a_ptr_d;
    b_ptr_q <= b_ptr_d;
    mac_q   <= mac_d;
    dst_q   <= dst_d;
    cnt_q   <= cnt_d;
    rdata_q <= rdata_d;
  end

`ifdef CM3_MAC_MASTER_CYCLE_CNT_EN
  logic [31:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if (state_q == S_IDLE && start) begin
      cyc_d = '0;
    end else if (busy && cyc_q != 32'hFFFF_FFFF) begin
      cyc_d = cyc_q + 32'd1;
    end
  end

  always_ff @(posedge hclk) begin
    if (rst) cyc_q <= '0;
    else     cyc_q <= cyc_d;
  end

  assign cycle_cnt = cyc_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: tb/tb_cm3_mac_ahb_master.sv
// Directed bench for cm3_mac_ahb_master: an AHB slave model with optional
// wait states and ERROR injection backs both word memory and the MAC map.
module tb_cm3_mac_ahb_master;

  logic        hclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_a, src_b, mac_base, dst;
  logic [15:0] len;
  logic        busy, done, error;
  logic [31:0] cycle_cnt;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize, hburst;
  logic [31:0] hwdata;
  logic [31:0] hrdata = 32'h0;
  logic        hready = 1'b1;
  logic        hresp = 1'b0;

  cm3_mac_ahb_master #(.LEN_W(16), .ADDR_W(32)) dut (
    .hclk(hclk), .rst(rst), .start(start),
    .src_a(src_a), .src_b(src_b), .mac_base(mac_base), .dst(dst), .len(len),
    .busy(busy), .done(done), .error(error), .cycle_cnt(cycle_cnt),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata), .hrdata(hrdata), .hready(hready),
    .hresp(hresp)
  );

  always #5 hclk = ~hclk;

  // Test-side controls (written only by the stimulus process).
  logic [31:0] mem [logic [31:0]];
  int          aw_cfg = 0, dw_cfg = 0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] acc_preset = 32'h0;
  int          clr_seq = 0;

  // Model state (written only by the slave model).
  int          clr_seen = 0;
  bit          in_data = 1'b0, d_write = 1'b0, d_first = 1'b0, d_err = 1'b0;
  bit          hold_addr_v = 1'b0, err_watch = 1'b0;
  int          aw_left = 0, dw_left = 0, err_stage = 0;
  logic [31:0] d_addr = 32'h0, hold_addr = 32'h0, hold_wdata = 32'h0;
  logic [31:0] mac_a_reg = 32'h0, mac_acc = 32'h0;
  logic [31:0] wq_addr[$], wq_data[$];
  int          rd_res_cnt = 0, n_reads = 0, busy_cycles = 0, done_cnt = 0;
  int          stab_err = 0;
  logic [31:0] err_htrans0 = 32'hFFFF_FFFF, post_err_htrans = 32'hFFFF_FFFF;
  logic [31:0] post_err_done = 32'h0;

  int n_cmp = 0, n_bad = 0;
  logic [31:0] ea[8], ed[8];

  // Slave + monitor: decides hready/hresp/hrdata for the coming edge.
  always @(negedge hclk) begin
    if (clr_seq != clr_seen) begin
      clr_seen = clr_seq;
      in_data = 1'b0; hold_addr_v = 1'b0; err_watch = 1'b0;
      aw_left = aw_cfg;
      wq_addr.delete(); wq_data.delete();
      rd_res_cnt = 0; n_reads = 0; busy_cycles = 0; done_cnt = 0; stab_err = 0;
      mac_acc = acc_preset; mac_a_reg = 32'h0;
      err_htrans0 = 32'hFFFF_FFFF; post_err_htrans = 32'hFFFF_FFFF; post_err_done = 32'h0;
    end
    if (busy) busy_cycles++;
    if (done) done_cnt++;
    if (err_watch) begin
      post_err_htrans = 32'(htrans);
      post_err_done   = 32'(done);
      err_watch = 1'b0;
    end
    hresp = 1'b0;
    if (in_data) begin
      if (d_first) begin
        hold_wdata = hwdata;
        d_first = 1'b0;
      end else if (d_write && hwdata !== hold_wdata) begin
        stab_err++;
      end
      if (d_err) begin
        if (err_stage == 0) begin
          hready = 1'b0; hresp = 1'b1; err_stage = 1;
          err_htrans0 = 32'(htrans); err_watch = 1'b1;
        end else begin
          hready = 1'b1; hresp = 1'b1; in_data = 1'b0; aw_left = aw_cfg;
        end
      end else if (dw_left > 0) begin
        hready = 1'b0;
        dw_left--;
      end else begin
        hready = 1'b1;
        in_data = 1'b0;
        aw_left = aw_cfg;
        if (d_write) begin
          wq_addr.push_back(d_addr);
          wq_data.push_back(hwdata);
          if (d_addr == mac_base) mac_a_reg = hwdata;
          else if (d_addr == mac_base + 32'd4) mac_acc = mac_acc + mac_a_reg * hwdata;
        end else begin
          n_reads++;
          if (d_addr == mac_base + 32'd8) begin
            hrdata = mac_acc; mac_acc = 32'h0; rd_res_cnt++;
          end else begin
            hrdata = mem.exists(d_addr) ? mem[d_addr] : 32'h0;
          end
        end
      end
    end else if (htrans == 2'b10) begin
      if (!hold_addr_v) begin
        hold_addr = haddr; hold_addr_v = 1'b1;
      end else if (haddr !== hold_addr) begin
        stab_err++;
      end
      if (aw_left > 0) begin
        hready = 1'b0;
        aw_left--;
      end else begin
        hready = 1'b1; in_data = 1'b1; d_first = 1'b1; hold_addr_v = 1'b0;
        d_addr = haddr; d_write = hwrite; dw_left = dw_cfg;
        d_err = err_en && (haddr == err_addr) && !hwrite;
        err_stage = 0;
      end
    end else begin
      hready = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_cc(input logic [31:0] v);
`ifdef CM3_MAC_MASTER_CYCLE_CNT_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  task automatic run_job(input logic [15:0] l);
    @(posedge hclk); #1;
    clr_seq++;
    len = l;
    start = 1'b1;
    @(posedge hclk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit f;
    f = 1'b0;
    for (int i = 0; i < 2000 && !f; i++) begin
      @(negedge hclk);
      if (done) f = 1'b1;
    end
    chk({tag, "_done_seen"}, 32'(f), 32'd1);
    repeat (3) @(posedge hclk);
    #1;
  endtask

  task automatic check_writes(input string tag, input int n);
    chk({tag, "_nwr"}, 32'(wq_addr.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < wq_addr.size()) begin
        chk($sformatf("%s_wa%0d", tag, i), wq_addr[i], ea[i]);
        chk($sformatf("%s_wd%0d", tag, i), wq_data[i], ed[i]);
      end
    end
  endtask

  task automatic set_exp_std();
    ea[0] = mac_base; ed[0] = 32'd1;
    ea[1] = mac_base + 32'd4; ed[1] = 32'd4;
    ea[2] = mac_base; ed[2] = 32'd2;
    ea[3] = mac_base + 32'd4; ed[3] = 32'd5;
    ea[4] = mac_base; ed[4] = 32'd3;
    ea[5] = mac_base + 32'd4; ed[5] = 32'd6;
    ea[6] = dst; ed[6] = 32'd32;
  endtask

  task automatic check_std(input string tag, input int exp_busy);
    set_exp_std();
    check_writes(tag, 7);
    chk({tag, "_nreads"}, 32'(n_reads), 32'd7);
    chk({tag, "_resreads"}, 32'(rd_res_cnt), 32'd1);
    chk({tag, "_busy"}, 32'(busy_cycles), 32'(exp_busy));
    chk({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_stable"}, 32'(stab_err), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    src_a = 32'h0000_1000; src_b = 32'h0000_2000;
    mac_base = 32'h4000_0000; dst = 32'h0000_3000; len = 16'd0;
    mem[32'h1000] = 32'd1; mem[32'h1004] = 32'd2; mem[32'h1008] = 32'd3; mem[32'h100C] = 32'd4;
    mem[32'h2000] = 32'd4; mem[32'h2004] = 32'd5; mem[32'h2008] = 32'd6; mem[32'h200C] = 32'd8;

    // Reset state
    repeat (3) @(posedge hclk);
    #1 rst = 1'b0;
    @(negedge hclk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_htrans", 32'(htrans), 32'd0);
    chk("rst_haddr", haddr, 32'd0);
    chk("rst_hwrite", 32'(hwrite), 32'd0);
    chk("rst_hwdata", hwdata, 32'd0);
    chk("rst_cycle_cnt", cycle_cnt, 32'd0);
    chk("hsize", 32'(hsize), 32'd2);
    chk("hburst", 32'(hburst), 32'd0);

    // Zero-wait len=3 dot product: 1*4+2*5+3*6 = 32
    run_job(16'd3);
    wait_done("zw");
    check_std("zw", 28);
    chk("zw_cycle_cnt", cycle_cnt, exp_cc(32'd28));

    // Wait states: 1 address + 2 data waits on each of 14 transfers -> 28+42
    aw_cfg = 1; dw_cfg = 2;
    run_job(16'd3);
    wait_done("ws");
    check_std("ws", 70);
    chk("ws_cycle_cnt", cycle_cnt, exp_cc(32'd70));
    aw_cfg = 0; dw_cfg = 0;

    // len=0 flushes a preloaded accumulator value to dst
    acc_preset = 32'd7;
    run_job(16'd0);
    wait_done("l0");
    acc_preset = 32'd0;
    ea[0] = dst; ed[0] = 32'd7;
    check_writes("l0", 1);
    chk("l0_nreads", 32'(n_reads), 32'd1);
    chk("l0_resreads", 32'(rd_res_cnt), 32'd1);
    chk("l0_busy", 32'(busy_cycles), 32'd4);
    chk("l0_done_cnt", 32'(done_cnt), 32'd1);
    chk("l0_cycle_cnt", cycle_cnt, exp_cc(32'd4));

    // ERROR on read of src_b+4 with len=4: abort after element 1's A write
    err_en = 1'b1; err_addr = 32'h0000_2004;
    run_job(16'd4);
    wait_done("er");
    err_en = 1'b0;
    ea[0] = mac_base; ed[0] = 32'd1;
    ea[1] = mac_base + 32'd4; ed[1] = 32'd4;
    ea[2] = mac_base; ed[2] = 32'd2;
    check_writes("er", 3);
    chk("er_error", 32'(error), 32'd1);
    chk("er_done_cnt", 32'(done_cnt), 32'd1);
    chk("er_htrans_first", err_htrans0, 32'd0);
    chk("er_htrans_next", post_err_htrans, 32'd0);
    chk("er_done_next", post_err_done, 32'd1);
    chk("er_resreads", 32'(rd_res_cnt), 32'd0);
    chk("er_busy", 32'(busy_cycles), 32'd14);

    // start pulse while busy (with different inputs) is ignored
    run_job(16'd3);
    repeat (9) @(posedge hclk);
    #1;
    start = 1'b1; len = 16'd1; src_a = 32'h0000_5000;
    @(posedge hclk); #1;
    start = 1'b0; len = 16'd3; src_a = 32'h0000_1000;
    wait_done("sb");
    check_std("sb", 28);

    // Reset mid-element abandons the job with no done pulse
    run_job(16'd3);
    repeat (4) @(posedge hclk);
    #1 rst = 1'b1;
    @(posedge hclk); #1;
    rst = 1'b0;
    clr_seq++;
    @(negedge hclk);
    chk("mr_htrans", 32'(htrans), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    repeat (12) @(posedge hclk);
    #1;
    chk("mr_no_done", 32'(done_cnt), 32'd0);
    chk("mr_error", 32'(error), 32'd0);
    run_job(16'd3);
    wait_done("rr");
    check_std("rr", 28);
    chk("rr_cycle_cnt", cycle_cnt, exp_cc(32'd28));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
